// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N valid/ready input channels funnelled into one output stream.
// The mux uses the slave modport and the producer/consumer side uses the master modport.
interface stream_mux_rr_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with explicit-select or round-robin grant and a single
// registered output stage (one-cycle latency, one beat per cycle).
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_rr_if.slave bus
);

  logic [SELW-1:0]  ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_ch_r;

  logic [SELW-1:0]  grant_s;
  logic             grant_valid_s;
  logic [SELW-1:0]  hi_s;
  logic             hi_found_s;
  logic [SELW-1:0]  lo_s;
  logic             load_s;
  logic [NCH-1:0]   ready_s;
  logic [WIDTH-1:0] data_s;
  logic             xfer_s;

  assign load_s = !out_valid_r || bus.out_ready;

  // Grant selection: explicit select, or first valid channel at/after ptr with wrap to the lowest.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    hi_s          = '0;
    hi_found_s    = 1'b0;
    lo_s          = '0;
    // Descending scan so the lowest qualifying index is the one left in hi_s/lo_s.
    for (int i = NCH - 1; i >= 0; i--) begin
      hi_s       = (bus.in_valid[i] && (SELW'(i) >= ptr_r)) ? SELW'(i) : hi_s;
      hi_found_s = hi_found_s | (bus.in_valid[i] && (SELW'(i) >= ptr_r));
      lo_s       = bus.in_valid[i] ? SELW'(i) : lo_s;
    end
    if (!bus.mode) begin
      grant_s = bus.sel;
      for (int i = 0; i < NCH; i++) begin
        grant_valid_s = grant_valid_s | ((bus.sel == SELW'(i)) & bus.in_valid[i]);
      end
    end else begin
      grant_s       = hi_found_s ? hi_s : lo_s;
      grant_valid_s = |bus.in_valid;
    end
  end

  // One-hot ready toward the granted producer and the matching data lane.
  always_comb begin
    ready_s = '0;
    data_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      ready_s[i] = load_s & grant_valid_s & rst_n & (grant_s == SELW'(i));
      data_s     = (grant_s == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : data_s;
    end
    xfer_s = |(bus.in_valid & ready_s);
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      ptr_r       <= '0;
    end else begin
      if (load_s) begin
        if (xfer_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= data_s;
          out_ch_r    <= grant_s;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
      // Explicit wrap keeps non-power-of-two channel counts correct.
      if (xfer_s && bus.mode) begin
        ptr_r <= (grant_s == SELW'(NCH - 1)) ? '0 : grant_s + SELW'(1);
      end
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench: a 4-channel and a 3-channel mux compared every cycle against a
// behavioural model, plus directed hand-computed expectations.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(32), .NCH(4), .SELW(2)) ia ();
  stream_mux_rr_if #(.WIDTH(32), .NCH(3), .SELW(2)) ib ();

  stream_mux_rr #(.WIDTH(32), .NCH(4), .SELW(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  stream_mux_rr #(.WIDTH(32), .NCH(3), .SELW(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  typedef struct {
    bit          ov;
    logic [31:0] od;
    int          oc;
    int          ptr;
  } mst_t;

  mst_t ma = '{ov: 1'b0, od: 32'd0, oc: 0, ptr: 0};
  mst_t mb = '{ov: 1'b0, od: 32'd0, oc: 0, ptr: 0};
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grant by the rules: explicit sel, or first valid channel scanning ptr, ptr+1, ... modulo n.
  function automatic void grant(int n, bit mode, int sel, logic [15:0] v, int ptr,
                                output int g, output bit gv);
    g  = 0;
    gv = 1'b0;
    if (!mode) begin
      g  = sel;
      gv = (sel < n) && v[sel];
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (ptr + k) % n;
        if (!gv && v[c]) begin
          g  = c;
          gv = 1'b1;
        end
      end
    end
  endfunction

  function automatic mst_t nxt(mst_t s, int n, bit rst, bit mode, int sel, logic [15:0] v,
                               logic [511:0] d, bit ordy);
    mst_t r;
    int   g;
    bit   gv;
    r = s;
    if (!rst) begin
      r.ov = 1'b0; r.od = 32'd0; r.oc = 0; r.ptr = 0;
    end else if (!s.ov || ordy) begin
      grant(n, mode, sel, v, s.ptr, g, gv);
      if (gv) begin
        r.ov = 1'b1;
        r.od = d[g*32 +: 32];
        r.oc = g;
        if (mode) r.ptr = (g + 1) % n;
      end else begin
        r.ov = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic cmp(string nm, mst_t m, int n, bit mode, int sel, logic [15:0] v, bit ordy,
                     logic [15:0] rdy, bit ov, logic [31:0] od, int oc);
    int          g;
    bit          gv;
    logic [15:0] exp_rdy;
    grant(n, mode, sel, v, m.ptr, g, gv);
    exp_rdy = (rst_n && (!m.ov || ordy) && gv) ? (16'd1 << g) : 16'd0;
    check({nm, "_in_ready"}, 64'(rdy), 64'(exp_rdy));
    check({nm, "_out_valid"}, 64'(ov), 64'(m.ov));
    check({nm, "_out_data"}, 64'(od), 64'(m.od));
    check({nm, "_out_ch"}, 64'(oc), 64'(m.oc));
  endtask

  // Model state advances on the same edge as the DUTs.
  always @(posedge clk) begin
    ma <= nxt(ma, 4, rst_n, ia.mode, int'(ia.sel), 16'(ia.in_valid), 512'(ia.in_data), ia.out_ready);
    mb <= nxt(mb, 3, rst_n, ib.mode, int'(ib.sel), 16'(ib.in_valid), 512'(ib.in_data), ib.out_ready);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", ma, 4, ia.mode, int'(ia.sel), 16'(ia.in_valid), ia.out_ready, 16'(ia.in_ready),
          ia.out_valid, ia.out_data, int'(ia.out_ch));
      cmp("b", mb, 3, ib.mode, int'(ib.sel), 16'(ib.in_valid), ib.out_ready, 16'(ib.in_ready),
          ib.out_valid, ib.out_data, int'(ib.out_ch));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) ia.in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) ib.in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
  endtask

  initial begin
    rst_n = 1'b0;
    ia.mode = 1'b1; ia.sel = 2'd0; ia.in_valid = 4'hF; ia.out_ready = 1'b1;
    ib.mode = 1'b1; ib.sel = 2'd0; ib.in_valid = 3'h7; ib.out_ready = 1'b1;
    set_data();
    cyc();
    chk_en = 1'b1;
    #1;
    check("rst_in_ready", 64'(ia.in_ready), 64'd0);
    check("rst_out_valid", 64'(ia.out_valid), 64'd0);
    check("rst_out_data", 64'(ia.out_data), 64'd0);
    check("rst_out_ch", 64'(ia.out_ch), 64'd0);
    cyc();
    rst_n = 1'b1;
    ib.in_valid = 3'b000;
    #1 check("first_grant", 64'(ia.in_ready), 64'h1);

    // Round-robin fairness with all channels valid.
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("rr_seq_ch", 64'(ia.out_ch), 64'(k % 4));
      check("rr_seq_valid", 64'(ia.out_valid), 64'd1);
    end

    // Explicit select.
    ia.mode = 1'b0; ia.sel = 2'd2; ia.in_data[2*32 +: 32] = 32'hDEADBEEF;
    #1 check("sel2_ready", 64'(ia.in_ready), 64'h4);
    cyc();
    check("sel2_data", 64'(ia.out_data), 64'hDEADBEEF);
    check("sel2_ch", 64'(ia.out_ch), 64'd2);
    ia.sel = 2'd3; ia.in_valid = 4'b0111;
    #1 check("sel3_ready", 64'(ia.in_ready), 64'h0);
    cyc();
    check("sel3_valid_drop", 64'(ia.out_valid), 64'd0);

    // Skip and wrap: ptr is 2 here, ch2 moves it to 3.
    set_data();
    ia.mode = 1'b1; ia.in_valid = 4'b0100;
    cyc();
    ia.in_valid = 4'b0010;
    #1 check("skip_ready", 64'(ia.in_ready), 64'h2);
    cyc();
    check("skip_ch", 64'(ia.out_ch), 64'd1);
    ia.in_valid = 4'b1001;
    #1 check("wrap_ready3", 64'(ia.in_ready), 64'h8);
    cyc();
    check("wrap_ch3", 64'(ia.out_ch), 64'd3);
    #1 check("wrap_ready0", 64'(ia.in_ready), 64'h1);

    // Backpressure: hold the ch3 beat for five cycles.
    ia.out_ready = 1'b0; ia.in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_ready", 64'(ia.in_ready), 64'h0);
      cyc();
      check("bp_data", 64'(ia.out_data), 64'hA000_0003);
      check("bp_ch", 64'(ia.out_ch), 64'd3);
    end
    ia.out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(ia.in_ready), 64'h1);
    cyc();
    check("bp_release_ch", 64'(ia.out_ch), 64'd0);
    check("bp_release_data", 64'(ia.out_data), 64'hA000_0000);

    // Three-channel instance: sel=3 never granted, round-robin wraps 2->0.
    ib.mode = 1'b0; ib.sel = 2'd3; ib.in_valid = 3'b111;
    #1 check("b_sel3_ready", 64'(ib.in_ready), 64'h0);
    cyc();
    check("b_sel3_valid", 64'(ib.out_valid), 64'd0);
    ib.mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("b_rr_ch", 64'(ib.out_ch), 64'(k % 3));
    end
    ib.out_ready = 1'b0;
    cyc();
    cyc();
    check("b_stall_ch", 64'(ib.out_ch), 64'd0);
    check("b_stall_valid", 64'(ib.out_valid), 64'd1);
    rst_n = 1'b0;
    #1 check("b_rst_ready", 64'(ib.in_ready), 64'h0);
    cyc();
    check("b_rst_valid", 64'(ib.out_valid), 64'd0);
    check("b_rst_data", 64'(ib.out_data), 64'd0);
    rst_n = 1'b1;

    // Randomized traffic checked by the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      ia.mode      = 1'($urandom_range(0, 1));
      ia.sel       = 2'($urandom_range(0, 3));
      ia.in_valid  = 4'($urandom);
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ib.mode      = 1'($urandom_range(0, 1));
      ib.sel       = 2'($urandom_range(0, 3));
      ib.in_valid  = 3'($urandom);
      ib.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) ia.in_data[i*32 +: 32] = $urandom;
      for (int i = 0; i < 3; i++) ib.in_data[i*32 +: 32] = $urandom;
      cyc();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes: explicit select (a clocked analogue of the combinational 2/4/8-way muxes) and round-robin arbitration.
- A single registered output stage gives one-cycle latency and full one-beat-per-cycle throughput.
- Sits between multiple producers (e.g. writeback sources, bus masters) and one consumer in the datapath.

Parameters:
- WIDTH, 32, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, select/channel-index width; must satisfy 2^SELW >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode=0.
- in_valid  input  NCH  per-channel valid; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel ready; combinational, at most one bit high.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  channel index the held beat came from.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is 0 while rst_n=0. Reset mid-stall discards the held beat.
- load = !out_valid || out_ready (output stage empty or draining this cycle).
- Grant (combinational, every cycle):
  - mode=0: g=sel; grant valid iff sel<NCH and in_valid[sel]=1. sel>=NCH never grants.
  - mode=1: g = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1; grant valid iff any in_valid bit is set.
- in_ready[g] = load && grant_valid && rst_n; every other in_ready bit is 0. A producer may hold valid indefinitely; in_ready never depends on that channel's own in_data.
- Transfer on channel g occurs when in_valid[g] && in_ready[g].
- At each clk edge:
  - If load and transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - If load and no transfer: out_valid <= 0; out_data and out_ch hold their values.
  - If !load: all outputs hold. out_data and out_ch must stay stable while out_valid && !out_ready.
- Pointer update:
  - Only on a transfer in mode=1: ptr <= (g==NCH-1) ? 0 : g+1. Wrap-around is explicit, with no 2^SELW modulo, so non-power-of-2 NCH works.
  - mode=0 transfers leave ptr unchanged.
- Mode or sel changes take effect in the same cycle (combinational grant). A beat already in the output register is unaffected.
- Latency: input transfer to out_valid is 1 cycle. Throughput is 1 beat/cycle when out_ready=1 continuously.
- Simultaneous drain and fill (out_valid=1, out_ready=1, new transfer): the output is replaced by the new beat with no bubble.
- No beat is dropped or duplicated. Each input transfer yields exactly one output beat.

Test Plan:
- Reset: drive rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 after the edge. Release -> first grant is channel 0 in mode=1.
- Explicit select: mode=0, sel=2, in_valid=4'b1111, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=DEADBEEF, out_ch=2. sel=3 with in_valid[3]=0 -> in_ready=0, out_valid drops the following cycle.
- Round-robin fairness: mode=1, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle, no bubbles.
- Round-robin skip/wrap: ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2. Then in_valid=4'b1001 -> grant ch3, ptr wraps to 0.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> in_ready=0 and out_data/out_ch unchanged throughout. Raise out_ready -> held beat accepted and next beat loaded the same edge.
- Mid-stall reset plus NCH=3 build (SELW=2): stalled beat, assert rst_n=0 -> out_valid=0 next edge. mode=0, sel=3 -> never granted. Round-robin wraps 2->0.
